// File: rtl/crc16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc16_pkg
// Purpose  : Shared CRC-16 constants and receive FSM state encoding used by
//            the serial CRC generator and checker.
// Revision : 1.0 - initial release
// ============================================================================
package crc16_pkg;

  // x^16 + x^15 + x^2 + 1, non-reflected, MSB-first
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  // LFSR preset applied at the first bit of every frame
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  // Shortest legal frame: one payload bit plus the 16-bit CRC
  localparam int          CRC16_MIN_FRAME = 17;

  // Receive FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } crc_state_e;

endpackage
`default_nettype wire

// File: rtl/crc16_serial_step.sv
`default_nettype none
// ============================================================================
// Module   : crc16_serial_step
// Purpose  : One bit-serial CRC-16 LFSR step. Pure combinational so the
//            transmit and receive sides share bit-exact arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_serial_step (
  input  logic [15:0] lfsr,
  input  logic        data_bit,
  input  logic [15:0] poly,
  output logic [15:0] lfsr_next
);

  logic w_fb;

  // Feedback is the incoming bit against the register MSB; shift left and
  // fold the polynomial in when feedback is set.
  always_comb begin
    w_fb      = data_bit ^ lfsr[15];
    lfsr_next = {lfsr[14:0], 1'b0} ^ (w_fb ? poly : 16'h0000);
  end

endmodule
`default_nettype wire

// File: rtl/serial_crc_checker.sv
`default_nettype none
// ============================================================================
// Module   : serial_crc_checker
// Purpose  : Receive-side CRC-16 checker. Runs the generator LFSR over the
//            whole bit-serial frame (payload then CRC, both MSB-first) and
//            reports pass/fail by zero residue, plus length errors and a
//            saturating failed-frame count.
// Revision : 1.0 - initial release
// ============================================================================
module serial_crc_checker
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY     = CRC16_POLY,
  parameter logic [15:0] INIT     = CRC16_INIT,
  parameter int          MAX_BITS = 4096,
  parameter int          CNT_W    = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_start,
  input  logic             frame_end,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [15:0]      residue,
  output logic [15:0]      rx_crc,
  output logic [CNT_W-1:0] bit_count,
  output logic [15:0]      err_count
);

  localparam logic [CNT_W-1:0] c_min_cnt = CNT_W'(CRC16_MIN_FRAME);
  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_BITS);

  crc_state_e       r_state;
  crc_state_e       w_state_nxt;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_nxt;
  logic [15:0]      w_step_base;
  logic [15:0]      w_step_out;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      w_rx_nxt;
  logic             w_start;
  logic             w_finish;
  logic             w_clear;
  logic             w_len_bad;
  logic             w_pass;

  // A valid frame_start restarts from the preset regardless of state
  assign w_start     = bit_valid & frame_start;
  assign w_step_base = w_start ? INIT : r_lfsr;

  crc16_serial_step u_step (
    .lfsr      (w_step_base),
    .data_bit  (bit_in),
    .poly      (POLY),
    .lfsr_next (w_step_out)
  );

  // Bit counter holds at all-ones once it saturates
  assign w_cnt_inc = (bit_count == {CNT_W{1'b1}}) ? bit_count
                                                  : bit_count + CNT_W'(1);

  // Next-state, datapath update and end-of-frame detection
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = bit_count;
    w_rx_nxt    = rx_crc;
    w_finish    = 1'b0;
    w_clear     = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        // Fresh frame (or abort-and-restart when already receiving)
        w_lfsr_nxt  = w_step_out;
        w_cnt_nxt   = CNT_W'(1);
        w_rx_nxt    = {15'd0, bit_in};
        w_clear     = 1'b1;
        w_state_nxt = RECV;
        if (frame_end) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end else if (r_state == RECV) begin
        w_lfsr_nxt = w_step_out;
        w_cnt_nxt  = w_cnt_inc;
        w_rx_nxt   = {rx_crc[14:0], bit_in};
        if (frame_end) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    end
  end

  // Result of the frame including its final bit
  assign w_len_bad = (w_cnt_nxt < c_min_cnt) | (w_cnt_nxt > c_max_cnt);
  assign w_pass    = (w_lfsr_nxt == 16'h0000) & ~w_len_bad;

  // State, LFSR, counter and receive shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_lfsr    <= INIT;
      bit_count <= '0;
      rx_crc    <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      bit_count <= w_cnt_nxt;
      rx_crc    <= w_rx_nxt;
    end
  end

  // Registered result fields, done pulse and saturating failure count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      residue   <= INIT;
      err_count <= 16'h0000;
    end else begin
      done <= w_finish;
      if (w_finish) begin
        residue <= w_lfsr_nxt;
        crc_ok  <= w_pass;
        crc_err <= ~w_pass;
        len_err <= w_len_bad;
        if (!w_pass && (err_count != 16'hFFFF)) begin
          err_count <= err_count + 16'd1;
        end
      end else if (w_clear) begin
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
        len_err <= 1'b0;
      end
    end
  end

  // Frame in progress only while receiving
  assign busy = (r_state == RECV);

endmodule
`default_nettype wire

// File: tb/tb_serial_crc_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serial_crc_checker
// Purpose  : Scoreboard bench for serial_crc_checker with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_crc_checker;

  localparam int MAX_BITS = 4096;
  localparam int CNT_W    = 13;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             frame_start = 1'b0;
  logic             frame_end = 1'b0;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic             len_err;
  logic [15:0]      residue;
  logic [15:0]      rx_crc;
  logic [CNT_W-1:0] bit_count;
  logic [15:0]      err_count;

  serial_crc_checker #(
    .POLY     (16'h8005),
    .INIT     (16'hFFFF),
    .MAX_BITS (MAX_BITS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy),
    .done        (done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .len_err     (len_err),
    .residue     (residue),
    .rx_crc      (rx_crc),
    .bit_count   (bit_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Residue modes: 0 exact, 1 must be nonzero, 2 not checked
  typedef struct {
    logic        ok;
    logic        err;
    logic        len;
    int          res_mode;
    logic [15:0] res;
    bit          rx_chk;
    logic [15:0] rx;
    int          cnt;
    int          errc;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // "123456789" followed by its CRC-16 (poly 8005, init FFFF) 0xAEE7
  logic [87:0] good_frame  = {72'h313233343536373839, 16'hAEE7};
  // One payload bit '0' followed by step(FFFF,0) = 0x7FFB
  logic [16:0] short_frame = {1'b0, 16'h7FFB};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic ok, input logic len, input int res_mode,
                              input logic [15:0] res, input bit rx_chk,
                              input logic [15:0] rx, input int cnt, input int errc);
    exp_t e;
    e.ok = ok; e.err = ~ok; e.len = len; e.res_mode = res_mode; e.res = res;
    e.rx_chk = rx_chk; e.rx = rx; e.cnt = cnt; e.errc = errc; e.due = 0;
    return e;
  endfunction

  // kind 0: good frame, 1: good frame with payload bit 5 flipped,
  // 2: alternating 0,1,..., 3: minimum-length good frame
  function automatic logic fbit(input int kind, input int i);
    case (kind)
      0:       return good_frame[87-i];
      1:       return good_frame[87-i] ^ (i == 5);
      3:       return short_frame[16-i];
      default: return i[0];
    endcase
  endfunction

  task automatic send_bit(input logic b, input logic s, input logic e);
    bit_valid = 1'b1; bit_in = b; frame_start = s; frame_end = e;
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
  endtask

  // Idle cycle with garbage on the qualified inputs
  task automatic junk_gap();
    bit_valid = 1'b0; bit_in = 1'b1; frame_start = 1'b1; frame_end = 1'b1;
    @(posedge clk); #1;
    bit_in = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int n, input int first, input bit gaps,
                            input bit term, input bit push, input bit chk_clear, input exp_t e);
    exp_t ee;
    ee = e;
    for (int i = first; i < n; i++) begin
      if (term && push && (i == n - 1)) begin
        ee.due = cyc + 1;
        sbq.push_back(ee);
      end
      send_bit(fbit(kind, i), (i == 0), term && (i == n - 1));
      if (chk_clear && (i == 0)) begin
        chk("start_clears_ok", crc_ok, 1'b0);
        chk("start_clears_err", crc_err, 1'b0);
        chk("start_busy", busy, 1'b1);
      end
      if (gaps && (i % 7 == 3)) junk_gap();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_crc_ok"}, crc_ok, 1'b0);
    chk({tag, "_crc_err"}, crc_err, 1'b0);
    chk({tag, "_len_err"}, len_err, 1'b0);
    chk({tag, "_residue"}, residue, 16'hFFFF);
    chk({tag, "_rx_crc"}, rx_crc, 16'h0000);
    chk({tag, "_bit_count"}, 32'(bit_count), 32'd0);
    chk({tag, "_err_count"}, err_count, 16'h0000);
  endtask

  // Monitor: pop and compare whenever the DUT presents a result
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        e = sbq.pop_front();
        chk("done_latency", cyc, e.due);
        chk("crc_ok", crc_ok, e.ok);
        chk("crc_err", crc_err, e.err);
        chk("len_err", len_err, e.len);
        if (e.res_mode == 0) chk("residue", residue, e.res);
        else if (e.res_mode == 1) chk("residue_nonzero", (residue != 16'h0000), 1'b1);
        if (e.rx_chk) chk("rx_crc", rx_crc, e.rx);
        chk("bit_count", 32'(bit_count), e.cnt);
        chk("err_count", err_count, e.errc);
        chk("busy_at_done", busy, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t g0, e;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_reset_vals("reset");

    // Bits without frame_start are dropped in IDLE
    send_frame(0, 10, 2, 0, 1, 0, 0, g0);
    chk("idle_drop_count", 32'(bit_count), 32'd0);
    chk("idle_drop_busy", busy, 1'b0);

    // Good frame with idle gaps carrying garbage control inputs
    e = mk(1'b1, 1'b0, 0, 16'h0000, 1, 16'hAEE7, 88, 0);
    send_frame(0, 88, 0, 1, 1, 1, 0, e);
    // Corrupted payload bit 5
    e = mk(1'b0, 1'b0, 1, 16'h0000, 1, 16'hAEE7, 88, 1);
    send_frame(1, 88, 0, 0, 1, 1, 0, e);
    // Short frames: 10 bits, then a 1-bit frame
    e = mk(1'b0, 1'b1, 2, 16'h0000, 0, 16'h0000, 10, 2);
    send_frame(2, 10, 0, 0, 1, 1, 0, e);
    e = mk(1'b0, 1'b1, 2, 16'h0000, 0, 16'h0000, 1, 3);
    send_frame(2, 1, 0, 0, 1, 1, 0, e);

    // Back-to-back: second start lands in the done cycle of the first
    e = mk(1'b1, 1'b0, 0, 16'h0000, 1, 16'hAEE7, 88, 3);
    send_frame(0, 88, 0, 0, 1, 1, 0, e);
    e = mk(1'b0, 1'b0, 1, 16'h0000, 1, 16'hAEE7, 88, 4);
    send_frame(1, 88, 0, 0, 1, 1, 1, e);

    // Abort after 40 bits, then a full good frame
    send_frame(0, 40, 0, 0, 0, 0, 0, g0);
    chk("abort_mid_busy", busy, 1'b1);
    chk("abort_mid_count", 32'(bit_count), 32'd40);
    e = mk(1'b1, 1'b0, 0, 16'h0000, 1, 16'hAEE7, 88, 4);
    send_frame(0, 88, 0, 0, 1, 1, 0, e);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset at bit 30 of a frame
    send_frame(0, 30, 0, 0, 0, 0, 0, g0);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    // Remainder of the lost frame has no frame_start and must be ignored
    send_frame(0, 88, 30, 0, 1, 0, 0, g0);
    chk("post_reset_drop_count", 32'(bit_count), 32'd0);
    e = mk(1'b1, 1'b0, 0, 16'h0000, 1, 16'hAEE7, 88, 0);
    send_frame(0, 88, 0, 0, 1, 1, 0, e);

    // Length boundaries: 17 bits legal, 16 bits illegal, MAX_BITS+1 illegal
    e = mk(1'b1, 1'b0, 0, 16'h0000, 1, 16'h7FFB, 17, 0);
    send_frame(3, 17, 0, 0, 1, 1, 0, e);
    e = mk(1'b0, 1'b1, 2, 16'h0000, 1, 16'h5555, 16, 1);
    send_frame(2, 16, 0, 0, 1, 1, 0, e);
    e = mk(1'b0, 1'b1, 2, 16'h0000, 0, 16'h0000, MAX_BITS + 1, 2);
    send_frame(2, MAX_BITS + 1, 0, 0, 1, 1, 0, e);

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("scoreboard_drain", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
